// File: rtl/sync_debounce_bank_pkg.sv
// Shared constants and helpers for board-input conditioning blocks.
// Holds the default synchroniser depth, the default debounce length and a constant clog2.
package sync_debounce_bank_pkg;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  // Constant-evaluable ceil(log2(value)). clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel. It holds a synchroniser chain, a debounce counter,
// the stable level and registered rise/fall pulses.
module debounce_channel
  import sync_debounce_bank_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int                CNT_W    = clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt;

  // The chain runs every cycle, whatever the value of enable, so it always carries fresh samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // NOTE: non-blocking defaults followed by later overrides give one-cycle pulses
  // without a second process; the last assignment in program order wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (enable) begin
        if (s == q) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          q    <= s;
          cnt  <= '0;
          rise <= s;
          fall <= ~s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/sync_debounce_bank.sv
// Bank of independent debounced inputs. The stable output is high when no
// channel has a pending transition.
module sync_debounce_bank
  import sync_debounce_bank_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] datos,
  output logic [WIDTH-1:0] Q_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             stable
);

  logic [WIDTH-1:0] busy;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .din    (datos[i]),
      .q      (Q_out[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .busy   (busy[i])
    );
  end

  assign stable = ~|busy;

endmodule
